// File: rtl/bgd_index_fetch.sv
// -----------------------------------------------------------------------------
// bgd_index_fetch
//
// Turns the VGA scan position into a background-ROM read address and returns
// the 4-bit palette index three cycles later, aligned with a valid flag. The
// 320x240 background is shown at 2x scale on 640x480. It supports horizontal
// wrap-around scrolling, either requested by the host or automatic. A new
// scroll value only takes effect on the frame-boundary cycle, so no frame
// ever mixes two scroll values.
//
// Ports
//   Clk, Reset     pixel clock; synchronous active-high reset
//   DrawX, DrawY   scan position (0..799, 0..524)
//   blank          1 during active video
//   scroll_x_in    requested scroll in texels; taken when scroll_valid &&
//                  scroll_ready are both high
//   scroll_ready   no request pending
//   auto_en        advance scroll by AUTO_STEP at each frame boundary
//   rom_addr       registered ROM address; ROM returns rom_q one Clk later
//   index          palette index, 3 cycles after the pixel was presented
//   index_valid    index belongs to an active, in-image pixel
//   scroll_ack     pulse when a pending request is applied
//   frame_tick     pulse following the frame-boundary cycle
// -----------------------------------------------------------------------------
module bgd_index_fetch #(
    parameter int unsigned IMG_W       = 320,
    parameter int unsigned IMG_H       = 240,
    parameter int unsigned SCALE_SHIFT = 1,
    parameter int unsigned ADDR_W      = 17,
    parameter int unsigned AUTO_STEP   = 1,
    parameter logic [3:0]  BG_IDX      = 4'h0
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic [8:0]        scroll_x_in,
    input  logic              scroll_valid,
    output logic              scroll_ready,
    input  logic              auto_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_q,
    output logic [3:0]       index,
    output logic              index_valid,
    output logic              scroll_ack,
    output logic              frame_tick
);

    localparam logic [9:0]  SCR_W_C  = 10'(IMG_W << SCALE_SHIFT);
    localparam logic [9:0]  SCR_H_C  = 10'(IMG_H << SCALE_SHIFT);
    localparam logic [10:0] IMG_W_11 = 11'(IMG_W);
    localparam logic [9:0]  IMG_W_10 = 10'(IMG_W);
    localparam logic [8:0]  IMG_W_9  = 9'(IMG_W);
    localparam logic [9:0]  STEP_10  = 10'(AUTO_STEP);

    // Scroll state
    logic [8:0]        scroll_x_q, scroll_x_d;
    logic [8:0]        pend_q, pend_d;
    logic              pend_v_q, pend_v_d;

    // Pipeline state
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              v1_q, v1_d;
    logic              v2_q;
    logic [3:0]        index_q, index_d;
    logic              index_v_q;
    logic              ack_q, ack_d;
    logic              tick_q, tick_d;

    // Combinational helpers
    logic              boundary;
    logic [10:0]       u0, u;
    logic [9:0]        v;
    logic [9:0]        auto_sum;
    logic [8:0]        auto_next;
    logic [8:0]        cap_val;

    always_comb begin
        boundary = (DrawY == SCR_H_C) && (DrawX == '0);
        v1_d     = blank && (DrawX < SCR_W_C) && (DrawY < SCR_H_C);

        // Horizontal texel coordinate with a single wrap. Scroll is always
        // below IMG_W, so one subtraction is enough.
        u0 = 11'(DrawX >> SCALE_SHIFT) + 11'(scroll_x_q);
        u  = (u0 >= IMG_W_11) ? (u0 - IMG_W_11) : u0;
        v  = DrawY >> SCALE_SHIFT;

        addr_d = '0;
        if (v1_d) begin
            addr_d = ADDR_W'(v) * ADDR_W'(IMG_W) + ADDR_W'(u);
        end

        // Stage 3 picks the background colour for pixels that are not visible.
        index_d = v2_q ? rom_q : BG_IDX;

        auto_sum  = 10'(scroll_x_q) + STEP_10;
        auto_next = (auto_sum >= IMG_W_10) ? 9'(auto_sum - IMG_W_10) : 9'(auto_sum);
        cap_val   = (scroll_x_in >= IMG_W_9) ? (scroll_x_in - IMG_W_9) : scroll_x_in;

        scroll_x_d = scroll_x_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;

        if (boundary) begin
            if (pend_v_q) begin
                scroll_x_d = pend_q;
                pend_v_d   = 1'b0;
            end else if (auto_en) begin
                scroll_x_d = auto_next;
            end
        end

        // Ready reflects the registered pending flag. A request taken on the
        // boundary cycle is held until the next boundary.
        if (scroll_valid && !pend_v_q) begin
            pend_d   = cap_val;
            pend_v_d = 1'b1;
        end

        ack_d  = boundary && pend_v_q;
        tick_d = boundary;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            scroll_x_q <= '0;
            pend_q     <= '0;
            pend_v_q   <= 1'b0;
            addr_q     <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            index_q    <= BG_IDX;
            index_v_q  <= 1'b0;
            ack_q      <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            scroll_x_q <= scroll_x_d;
            pend_q     <= pend_d;
            pend_v_q   <= pend_v_d;
            addr_q     <= addr_d;
            v1_q       <= v1_d;
            v2_q       <= v1_q;
            index_q    <= index_d;
            index_v_q  <= v2_q;
            ack_q      <= ack_d;
            tick_q     <= tick_d;
        end
    end

    assign rom_addr     = addr_q;
    assign index        = index_q;
    assign index_valid  = index_v_q;
    assign scroll_ack   = ack_q;
    assign frame_tick   = tick_q;
    assign scroll_ready = !pend_v_q;

endmodule

// File: tb/tb_bgd_index_fetch.sv
// -----------------------------------------------------------------------------
// Testbench for bgd_index_fetch. The ROM model returns addr[3:0] one clock
// after the address. BG_IDX is overridden to 4'hA so that a background pixel
// can be told apart from ROM data at address 0.
// -----------------------------------------------------------------------------
module tb_bgd_index_fetch;

    localparam logic [3:0] BG = 4'hA;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX, DrawY;
    logic        blank;
    logic [8:0]  scroll_x_in;
    logic        scroll_valid;
    logic        scroll_ready;
    logic        auto_en;
    logic [16:0] rom_addr;
    logic [3:0]  rom_q;
    logic [3:0]  index;
    logic        index_valid;
    logic        scroll_ack;
    logic        frame_tick;

    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_q <= rom_addr[3:0];

    bgd_index_fetch #(
        .IMG_W      (320),
        .IMG_H      (240),
        .SCALE_SHIFT(1),
        .ADDR_W     (17),
        .AUTO_STEP  (1),
        .BG_IDX     (BG)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .scroll_x_in (scroll_x_in),
        .scroll_valid(scroll_valid),
        .scroll_ready(scroll_ready),
        .auto_en     (auto_en),
        .rom_addr    (rom_addr),
        .rom_q       (rom_q),
        .index       (index),
        .index_valid (index_valid),
        .scroll_ack  (scroll_ack),
        .frame_tick  (frame_tick)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] idx;
        logic       vld;
    } exp_t;
    exp_t sbq[$];

    // Reference scroll state
    int m_scroll;
    int m_pend;
    bit m_pend_v;

    function automatic int exp_addr(int x, int y, int s, bit vis);
        int u;
        if (!vis) return 0;
        u = x / 2 + s;
        if (u >= 320) u = u - 320;
        return (y / 2) * 320 + u;
    endfunction

    function automatic void model_reset();
        m_scroll = 0;
        m_pend   = 0;
        m_pend_v = 1'b0;
        sbq.delete();
    endfunction

    // One pixel cycle using the inputs currently driven.
    task automatic step();
        bit   vis, bnd, exp_ack, old_pv;
        int   a;
        exp_t e, g;
        vis = blank && (DrawX < 640) && (DrawY < 480);
        a   = exp_addr(int'(DrawX), int'(DrawY), m_scroll, vis);
        e.idx = vis ? 4'(a) : BG;
        e.vld = vis;
        sbq.push_back(e);
        bnd     = (DrawX == 0) && (DrawY == 480);
        old_pv  = m_pend_v;
        exp_ack = bnd && old_pv;
        if (bnd) begin
            if (old_pv) begin
                m_scroll = m_pend;
                m_pend_v = 1'b0;
            end else if (auto_en) begin
                m_scroll = (m_scroll + 1) % 320;
            end
        end
        if (scroll_valid && !old_pv) begin
            m_pend   = (scroll_x_in >= 320) ? int'(scroll_x_in) - 320 : int'(scroll_x_in);
            m_pend_v = 1'b1;
        end

        @(posedge Clk);
        #1;
        total++;
        if (rom_addr !== 17'(a)) begin
            bad++;
            $display("FAIL addr x=%0d y=%0d got=%0d want=%0d", DrawX, DrawY, rom_addr, a);
        end
        total++;
        if (frame_tick !== bnd) begin
            bad++;
            $display("FAIL frame_tick got=%0b want=%0b", frame_tick, bnd);
        end
        total++;
        if (scroll_ack !== exp_ack) begin
            bad++;
            $display("FAIL scroll_ack got=%0b want=%0b", scroll_ack, exp_ack);
        end
        total++;
        if (scroll_ready !== !m_pend_v) begin
            bad++;
            $display("FAIL scroll_ready got=%0b want=%0b", scroll_ready, !m_pend_v);
        end
        if (sbq.size() == 3) begin
            g = sbq.pop_front();
            total++;
            if (index !== g.idx || index_valid !== g.vld) begin
                bad++;
                $display("FAIL index got=%h/%0b want=%h/%0b", index, index_valid, g.idx, g.vld);
            end
        end else begin
            total++;
            if (index !== BG || index_valid !== 1'b0) begin
                bad++;
                $display("FAIL flushed_index got=%h/%0b want=%h/0", index, index_valid, BG);
            end
        end
    endtask

    task automatic set_px(input int x, input int y, input bit b);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = b;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        set_px(5, 5, 1'b1);
        repeat (2) @(posedge Clk);
        #1;
        total++;
        if (rom_addr !== '0 || index !== BG || index_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_pipe addr=%0d index=%h valid=%0b want 0/%h/0", rom_addr, index, index_valid, BG);
        end
        total++;
        if (scroll_ack !== 1'b0 || frame_tick !== 1'b0 || scroll_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ctl ack=%0b tick=%0b ready=%0b want 0/0/1", scroll_ack, frame_tick, scroll_ready);
        end
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_sweep();
        set_px(2, 0, 1'b1);
        step();
        set_px(639, 479, 1'b1);
        step();
        total++;
        if (rom_addr !== 17'd76799) begin
            bad++;
            $display("FAIL corner_addr got=%0d want=76799", rom_addr);
        end
        set_px(0, 0, 1'b0);
        step();
        total++;
        if (index !== 4'd1 || index_valid !== 1'b1) begin
            bad++;
            $display("FAIL pixel_2_0 got=%h/%0b want=1/1", index, index_valid);
        end
        for (int y = 0; y < 525; y += 7) begin
            for (int x = 0; x < 800; x += 13) begin
                set_px(x, y, ($urandom_range(0, 7) != 0));
                step();
            end
        end
    endtask

    task automatic test_blank();
        set_px(10, 10, 1'b0);
        step();
        set_px(700, 10, 1'b1);
        step();
        total++;
        if (rom_addr !== '0) begin
            bad++;
            $display("FAIL offscreen_addr got=%0d want=0", rom_addr);
        end
        set_px(10, 500, 1'b1);
        step();
        total++;
        if (index !== BG || index_valid !== 1'b0) begin
            bad++;
            $display("FAIL blank_index got=%h/%0b want=%h/0", index, index_valid, BG);
        end
        step();
        step();
    endtask

    task automatic test_scroll_req();
        set_px(100, 100, 1'b1);
        scroll_x_in  = 9'd300;
        scroll_valid = 1'b1;
        step();
        scroll_valid = 1'b0;
        total++;
        if (scroll_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_drop got=%0b want=0", scroll_ready);
        end
        set_px(40, 0, 1'b1);
        step();
        total++;
        if (rom_addr !== 17'd20) begin
            bad++;
            $display("FAIL old_scroll_addr got=%0d want=20", rom_addr);
        end
        set_px(0, 480, 1'b0);
        step();
        total++;
        if (frame_tick !== 1'b1 || scroll_ack !== 1'b1) begin
            bad++;
            $display("FAIL boundary_pulse tick=%0b ack=%0b want 1/1", frame_tick, scroll_ack);
        end
        set_px(40, 0, 1'b1);
        step();
        total++;
        if (rom_addr !== '0) begin
            bad++;
            $display("FAIL wrap_addr got=%0d want=0", rom_addr);
        end
        set_px(50, 10, 1'b1);
        step();
    endtask

    // Returns the scroll currently in use, read as the address at (0,0).
    task automatic check_scroll(input int want, input string name);
        set_px(0, 0, 1'b1);
        step();
        total++;
        if (rom_addr !== 17'(want)) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, rom_addr, want);
        end
    endtask

    task automatic test_auto();
        // Start from scroll 0 so the auto steps land on 1, 2, 3.
        test_reset();
        auto_en = 1'b1;
        set_px(0, 480, 1'b0);
        step();
        check_scroll(1, "auto_1");
        set_px(0, 480, 1'b0);
        step();
        check_scroll(2, "auto_2");
        set_px(0, 480, 1'b0);
        scroll_x_in  = 9'd5;
        scroll_valid = 1'b1;
        step();
        scroll_valid = 1'b0;
        check_scroll(3, "auto_3");
        total++;
        if (scroll_ready !== 1'b0) begin
            bad++;
            $display("FAIL boundary_capture ready=%0b want=0", scroll_ready);
        end
        set_px(0, 480, 1'b0);
        step();
        check_scroll(5, "req_priority");
        set_px(5, 5, 1'b1);
        scroll_x_in  = 9'd330;
        scroll_valid = 1'b1;
        step();
        scroll_valid = 1'b0;
        set_px(0, 480, 1'b0);
        step();
        check_scroll(10, "req_330");
        auto_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        set_px(200, 50, 1'b1);
        scroll_x_in  = 9'd77;
        scroll_valid = 1'b1;
        step();
        scroll_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_px(300 + i * 2, 60, 1'b1);
            step();
        end
        Reset = 1'b1;
        set_px(320, 60, 1'b1);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();
        total++;
        if (index_valid !== 1'b0 || scroll_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset valid=%0b ready=%0b want 0/1", index_valid, scroll_ready);
        end
        check_scroll(0, "reset_scroll");
        step();
        step();
        set_px(0, 480, 1'b0);
        step();
        check_scroll(0, "pending_dropped");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0)
                set_px(0, 480, 1'b0);
            else
                set_px($urandom_range(0, 799), $urandom_range(0, 524), $urandom_range(0, 3) != 0);
            auto_en      = ($urandom_range(0, 1) == 1);
            scroll_valid = ($urandom_range(0, 7) == 0);
            scroll_x_in  = 9'($urandom_range(0, 511));
            step();
        end
        scroll_valid = 1'b0;
        auto_en      = 1'b0;
        set_px(0, 0, 1'b0);
        repeat (3) step();
    endtask

    initial begin
        Reset        = 1'b1;
        DrawX        = '0;
        DrawY        = '0;
        blank        = 1'b0;
        scroll_x_in  = '0;
        scroll_valid = 1'b0;
        auto_en      = 1'b0;
        model_reset();

        test_reset();
        test_sweep();
        test_blank();
        test_scroll_req();
        test_auto();
        test_reset_mid();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
